// File: rtl/rtc_bus_pkg.sv
// Shared types for the RTC bus controller: access FSM states, register indices
// and the V3023 register address map.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_REC,
        ST_DATA,
        ST_DATA_REC
    } bus_state_t;

    localparam int unsigned IDX_ANO      = 0;
    localparam int unsigned IDX_MES      = 1;
    localparam int unsigned IDX_DIA      = 2;
    localparam int unsigned IDX_HORAS    = 3;
    localparam int unsigned IDX_MINUTOS  = 4;
    localparam int unsigned IDX_SEGUNDOS = 5;
    localparam int unsigned IDX_HT       = 6;
    localparam int unsigned IDX_MT       = 7;
    localparam int unsigned IDX_ST       = 8;

    localparam int unsigned SWEEP_LEN = 9;

    function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
        case (idx)
            4'd0:    rtc_addr = 8'h26;
            4'd1:    rtc_addr = 8'h25;
            4'd2:    rtc_addr = 8'h24;
            4'd3:    rtc_addr = 8'h23;
            4'd4:    rtc_addr = 8'h22;
            4'd5:    rtc_addr = 8'h21;
            4'd6:    rtc_addr = 8'h43;
            4'd7:    rtc_addr = 8'h42;
            4'd8:    rtc_addr = 8'h41;
            default: rtc_addr = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// Single RTC bus access engine: address phase, recovery, data phase, recovery,
// each T_PHASE cycles long; back-to-back accesses chain without an idle gap.
module rtc_bus_cycle
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_PHASE = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       dir,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d_n,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata
);

    localparam int unsigned PW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(T_PHASE - 1);

    bus_state_t    state;
    bus_state_t    state_nx;
    logic [PW-1:0] ph;
    logic          phase_last;
    logic [7:0]    addr_q;
    logic [7:0]    data_q;
    logic          dir_q;

    assign phase_last = (ph == PH_LAST);
    assign done       = (state == ST_DATA_REC) && phase_last;
    // Ready on the last recovery cycle too, so a follow-on access starts with no gap
    assign ready      = (state == ST_IDLE) || done;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            ph     <= '0;
            addr_q <= '0;
            data_q <= '0;
            dir_q  <= 1'b0;
            rdata  <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE || phase_last)
                ph <= '0;
            else
                ph <= ph + 1'b1;
            if (go && ready) begin
                addr_q <= addr;
                data_q <= wdata;
                dir_q  <= dir;
            end
            if (state == ST_DATA && phase_last && !dir_q)
                rdata <= ad_in;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:     if (go)         state_nx = ST_ADDR;
            ST_ADDR:     if (phase_last) state_nx = ST_ADDR_REC;
            ST_ADDR_REC: if (phase_last) state_nx = ST_DATA;
            ST_DATA:     if (phase_last) state_nx = ST_DATA_REC;
            ST_DATA_REC: if (phase_last) state_nx = go ? ST_ADDR : ST_IDLE;
            default:                     state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n   = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        a_d_n  = 1'b1;
        ad_oe  = 1'b0;
        ad_out = '0;
        case (state)
            ST_ADDR: begin
                cs_n   = 1'b0;
                a_d_n  = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_q;
            end
            ST_ADDR_REC: begin
                cs_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = addr_q;
            end
            ST_DATA: begin
                cs_n = 1'b0;
                if (dir_q) begin
                    wr_n   = 1'b0;
                    ad_oe  = 1'b1;
                    ad_out = data_q;
                end else begin
                    rd_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rtc_bus_controller.sv
// RTC bus master: captures single-register write requests from the port bank and
// periodically sweeps all nine time/timer registers back into the *le outputs.
module rtc_bus_controller
    import rtc_bus_pkg::*;
#(
    parameter int unsigned T_PHASE     = 5,
    parameter int unsigned READ_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ano,
    input  logic [7:0] mes,
    input  logic [7:0] dia,
    input  logic [7:0] horas,
    input  logic [7:0] minutos,
    input  logic [7:0] segundos,
    input  logic [7:0] ht,
    input  logic [7:0] mt,
    input  logic [7:0] st,
    input  logic [8:0] Habilita,
    input  logic       start_wr,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       a_d_n,
    output logic [7:0] anole,
    output logic [7:0] mesle,
    output logic [7:0] diale,
    output logic [7:0] horasle,
    output logic [7:0] minutosle,
    output logic [7:0] segundosle,
    output logic [7:0] htle,
    output logic [7:0] mtle,
    output logic [7:0] stle,
    output logic       Listo_es
);

    localparam logic [31:0] PER_LAST = 32'(READ_PERIOD - 1);
    localparam logic [3:0]  IDX_LAST = 4'(SWEEP_LEN - 1);

    logic [7:0]  wr_bytes [SWEEP_LEN];
    logic [7:0]  le_q     [SWEEP_LEN];
    logic        pending;
    logic        sweep_active;
    logic        sweep_due;
    logic        sweep_start;
    logic [3:0]  cap_idx;
    logic [7:0]  cap_data;
    logic [3:0]  next_idx;
    logic [3:0]  cur_idx;
    logic        cur_wr;
    logic [31:0] per_cnt;
    logic [3:0]  sel_idx;
    logic [7:0]  sel_data;
    logic        sel_valid;
    logic        go;
    logic        go_wr;
    logic [3:0]  go_idx;
    logic        cyc_ready;
    logic        cyc_done;
    logic [7:0]  rdata;

    always_comb begin
        wr_bytes[IDX_ANO]      = ano;
        wr_bytes[IDX_MES]      = mes;
        wr_bytes[IDX_DIA]      = dia;
        wr_bytes[IDX_HORAS]    = horas;
        wr_bytes[IDX_MINUTOS]  = minutos;
        wr_bytes[IDX_SEGUNDOS] = segundos;
        wr_bytes[IDX_HT]       = ht;
        wr_bytes[IDX_MT]       = mt;
        wr_bytes[IDX_ST]       = st;
    end

    always_comb begin
        sel_idx  = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < SWEEP_LEN; i++) begin
            if (Habilita[i]) begin
                sel_idx  = 4'(i);
                sel_data = wr_bytes[i];
            end
        end
    end

    assign sel_valid = $onehot(Habilita);

    // An in-flight sweep is never split; otherwise a pending write beats a due sweep
    always_comb begin
        go     = 1'b0;
        go_wr  = 1'b0;
        go_idx = next_idx;
        if (cyc_ready) begin
            if (sweep_active) begin
                go = 1'b1;
            end else if (pending) begin
                go     = 1'b1;
                go_wr  = 1'b1;
                go_idx = cap_idx;
            end else if (sweep_due) begin
                go     = 1'b1;
                go_idx = '0;
            end
        end
    end

    assign sweep_start = go && !go_wr && !sweep_active;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending      <= 1'b0;
            sweep_active <= 1'b0;
            sweep_due    <= 1'b0;
            cap_idx      <= '0;
            cap_data     <= '0;
            next_idx     <= '0;
            cur_idx      <= '0;
            cur_wr       <= 1'b0;
            per_cnt      <= '0;
            for (int unsigned i = 0; i < SWEEP_LEN; i++)
                le_q[i] <= '0;
        end else begin
            if (per_cnt == PER_LAST)
                per_cnt <= '0;
            else
                per_cnt <= per_cnt + 1'b1;

            if (per_cnt == PER_LAST)
                sweep_due <= 1'b1;
            else if (sweep_start)
                sweep_due <= 1'b0;

            if (start_wr && sel_valid) begin
                pending  <= 1'b1;
                cap_idx  <= sel_idx;
                cap_data <= sel_data;
            end else if (go && go_wr) begin
                pending <= 1'b0;
            end

            if (sweep_start) begin
                sweep_active <= 1'b1;
                next_idx     <= 4'd1;
            end else if (go && sweep_active) begin
                if (next_idx == IDX_LAST)
                    sweep_active <= 1'b0;
                else
                    next_idx <= next_idx + 4'd1;
            end

            if (go) begin
                cur_idx <= go_idx;
                cur_wr  <= go_wr;
            end

            if (cyc_done && !cur_wr)
                le_q[cur_idx] <= rdata;
        end
    end

    assign Listo_es = reset && cyc_ready && !cyc_done && !pending && !sweep_active && !sweep_due;

    assign anole      = le_q[IDX_ANO];
    assign mesle      = le_q[IDX_MES];
    assign diale      = le_q[IDX_DIA];
    assign horasle    = le_q[IDX_HORAS];
    assign minutosle  = le_q[IDX_MINUTOS];
    assign segundosle = le_q[IDX_SEGUNDOS];
    assign htle       = le_q[IDX_HT];
    assign mtle       = le_q[IDX_MT];
    assign stle       = le_q[IDX_ST];

    rtc_bus_cycle #(
        .T_PHASE(T_PHASE)
    ) u_cycle (
        .clk   (clk),
        .reset (reset),
        .go    (go),
        .dir   (go_wr),
        .addr  (rtc_addr(go_idx)),
        .wdata (cap_data),
        .ad_in (ad_in),
        .ad_out(ad_out),
        .ad_oe (ad_oe),
        .cs_n  (cs_n),
        .rd_n  (rd_n),
        .wr_n  (wr_n),
        .a_d_n (a_d_n),
        .ready (cyc_ready),
        .done  (cyc_done),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Scoreboard bench for rtc_bus_controller: a bus monitor decodes every RTC access
// and checks it against queued expected writes and the fixed sweep order.
`timescale 1ns/1ps
module tb_rtc_bus_controller;

    localparam int unsigned TP = 2;
    localparam int unsigned RP = 200;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ano = '0, mes = '0, dia = '0, horas = '0, minutos = '0;
    logic [7:0] segundos = '0, ht = '0, mt = '0, st = '0;
    logic [8:0] Habilita = '0;
    logic       start_wr = 1'b0;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, cs_n, rd_n, wr_n, a_d_n;
    logic [7:0] anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle;
    logic       Listo_es;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;

    wr_t         wq[$];
    int unsigned sweep_pos   = 0;
    int unsigned sweeps_done = 0;
    int unsigned writes_seen = 0;
    logic        in_acc      = 1'b0;

    logic [7:0] sweep_addr [9] = '{8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h43, 8'h42, 8'h41};
    logic [7:0] sweep_val  [9] = '{8'hD9, 8'hDA, 8'hDB, 8'hDC, 8'hDD, 8'hDE, 8'hBC, 8'hBD, 8'hBE};
    logic [8:0] bad_hab    [2] = '{9'h000, 9'h003};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rtc_bus_controller #(
        .T_PHASE(TP),
        .READ_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset),
        .ano(ano), .mes(mes), .dia(dia), .horas(horas), .minutos(minutos),
        .segundos(segundos), .ht(ht), .mt(mt), .st(st),
        .Habilita(Habilita), .start_wr(start_wr), .ad_in(ad_in),
        .ad_out(ad_out), .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d_n(a_d_n),
        .anole(anole), .mesle(mesle), .diale(diale), .horasle(horasle),
        .minutosle(minutosle), .segundosle(segundosle), .htle(htle), .mtle(mtle), .stle(stle),
        .Listo_es(Listo_es)
    );

    // RTC pad model: latches the address phase, answers reads with address ^ 0xFF
    logic [7:0] rtc_latch = '0;
    always @(posedge clk) if (!cs_n && !a_d_n) rtc_latch <= ad_out;
    assign ad_in = !rd_n ? (rtc_latch ^ 8'hFF) : 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        wq.push_back(e);
    endtask

    // Called one tick after a posedge; leaves us one tick after the capturing edge
    task automatic issue(input logic [8:0] hab);
        Habilita = hab;
        start_wr = 1'b1;
        @(posedge clk);
        #1 start_wr = 1'b0;
    endtask

    // Bus monitor
    initial begin : monitor
        int unsigned low_cnt, acc_start, prev_start;
        logic [7:0]  acc_addr, acc_data;
        logic        saw_wr, saw_rd, oe_bad;
        wr_t         e;
        low_cnt = 0; acc_start = 0; prev_start = 0;
        acc_addr = '0; acc_data = '0; saw_wr = 0; saw_rd = 0; oe_bad = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_acc    = 1'b0;
                sweep_pos = 0;
            end else if (!in_acc) begin
                if (!cs_n) begin
                    in_acc    = 1'b1;
                    low_cnt   = 1;
                    acc_addr  = ad_out;
                    acc_start = cyc;
                    saw_wr = 0; saw_rd = 0; oe_bad = 0;
                    check("addr_phase_strobes", {a_d_n, wr_n, rd_n, ad_oe}, 4'b0011);
                end
            end else if (!cs_n) begin
                low_cnt++;
                if (a_d_n && !wr_n) begin
                    saw_wr   = 1'b1;
                    acc_data = ad_out;
                    if (!ad_oe) oe_bad = 1'b1;
                end
                if (!rd_n) begin
                    saw_rd = 1'b1;
                    if (ad_oe) oe_bad = 1'b1;
                end
            end else begin
                in_acc = 1'b0;
                check("access_len", low_cnt, 3 * TP);
                check("data_phase_oe", oe_bad, 0);
                if (saw_wr && !saw_rd) begin
                    writes_seen++;
                    check("write_not_in_sweep", sweep_pos, 0);
                    if (wq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", acc_addr, acc_data);
                    end else begin
                        e = wq.pop_front();
                        check("write_addr", acc_addr, e.addr);
                        check("write_data", acc_data, e.data);
                    end
                end else if (saw_rd && !saw_wr) begin
                    check("read_addr", acc_addr, sweep_addr[sweep_pos]);
                    if (sweep_pos > 0) check("read_spacing", acc_start - prev_start, 4 * TP);
                    prev_start = acc_start;
                    sweep_pos++;
                    if (sweep_pos == 9) begin
                        sweep_pos = 0;
                        sweeps_done++;
                    end
                end else begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL access_dir: got wr=%0b rd=%0b, expected exactly one", saw_wr, saw_rd);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200us, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int unsigned lo;
        logic        cs_seen, listo_min, ok;
        logic [7:0]  le_now [9];

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_strobes", {cs_n, rd_n, wr_n, a_d_n, ad_oe}, 5'b11110);
        check("reset_ad_out", ad_out, 0);
        check("reset_le_a", {anole, mesle, diale, horasle}, 0);
        check("reset_le_b", {minutosle, segundosle, htle, mtle}, 0);
        check("reset_le_c", stle, 0);
        check("reset_listo", Listo_es, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("listo_after_reset", Listo_es, 1);

        // Single write of minutos: 1 capture cycle + 8 bus cycles busy
        @(posedge clk);
        #1 minutos = 8'h45;
        expect_wr(8'h22, 8'h45);
        issue(9'b000010000);
        lo = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (Listo_es) break;
            lo++;
        end
        check("listo_busy_cycles", lo, 9);

        // Invalid selects produce no bus traffic
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1 issue(bad_hab[k]);
            cs_seen = 1'b0;
            listo_min = 1'b1;
            repeat (20) begin
                @(negedge clk);
                if (!cs_n) cs_seen = 1'b1;
                if (!Listo_es) listo_min = 1'b0;
            end
            check("invalid_hab_no_cs", cs_seen, 0);
            check("invalid_hab_listo", listo_min, 1);
        end

        // ano starts at once; segundos then horas overwrite the one-deep pending slot
        @(posedge clk);
        #1;
        ano = 8'h55; segundos = 8'h10; horas = 8'h12;
        expect_wr(8'h26, 8'h55);
        expect_wr(8'h23, 8'h12);
        Habilita = 9'b000000001;
        start_wr = 1'b1;
        @(posedge clk);
        #1 Habilita = 9'b000100000;
        @(posedge clk);
        #1 Habilita = 9'b000001000;
        @(posedge clk);
        #1 start_wr = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Listo_es) begin ok = 1'b1; break; end
        end
        check("double_write_idle", ok, 1);
        check("writes_after_double", writes_seen, 3);

        // First automatic sweep
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sweeps_done >= 1) begin ok = 1'b1; break; end
        end
        check("first_sweep_seen", ok, 1);
        repeat (4) @(negedge clk);
        le_now = '{anole, mesle, diale, horasle, minutosle, segundosle, htle, mtle, stle};
        for (int i = 0; i < 9; i++) check($sformatf("le_%0d", i), le_now[i], sweep_val[i]);

        // Write requested during the 3rd read of the second sweep
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sweeps_done == 1 && sweep_pos == 2 && in_acc) begin ok = 1'b1; break; end
        end
        check("third_read_seen", ok, 1);
        @(posedge clk);
        #1 st = 8'h30;
        expect_wr(8'h41, 8'h30);
        issue(9'b100000000);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sweeps_done >= 2 && wq.size() == 0 && Listo_es) begin ok = 1'b1; break; end
        end
        check("deferred_write_done", ok, 1);
        check("writes_after_sweep", writes_seen, 4);
        check("sweeps_count", sweeps_done, 2);

        // Reset asserted mid address phase
        @(posedge clk);
        #1 ano = 8'h77;
        issue(9'b000000001);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!cs_n && !a_d_n) begin ok = 1'b1; break; end
        end
        check("midreset_addr_seen", ok, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midreset_release", {cs_n, rd_n, wr_n, a_d_n, ad_oe}, 5'b11110);
        check("midreset_listo", Listo_es, 0);
        check("midreset_le", {anole, stle}, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(negedge clk);
        check("midreset_no_write", writes_seen, 4);
        check("queue_empty", wq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
